wavetable_poly: RTL and testbench
=================================

// Module: wavetable_poly
// PURPOSE
//  Time-multiplexed N-voice wavetable oscillator; next generation of the single-voice WAVETABLE block.
//  Each voice has its own phase accumulator, bank select and sub-oscillator.
//  Adjacent table samples are linearly interpolated.
//  Shares one synchronous wavetable RAM port with an external read/dump path.
//  Sits between the control/MIDI register file (fs, bank) and the voice mixer (dout).
// PARAMETERS
//  DATAWIDTH   16  sample width, offset-binary (0x8000 = midscale)
//  ADDRWIDTH   8   table index width (2^ADDRWIDTH samples per bank)
//  PHASEWIDTH  24  phase accumulator width; PHASEWIDTH >= ADDRWIDTH+FRACW
//  FRACW       8   fraction bits used by the interpolator
//  BANKW       2   bank select width
//  NVOICES     4   number of voices
// PORTS
//  clk              in   1                    system clock; all logic on posedge
//  rst_n            in   1                    reset, asynchronous, active-low
//  sample_tick      in   1                    one-cycle pulse that starts a frame
//  voice_fs         in   NVOICES*PHASEWIDTH   per-voice phase increment; voice v = [v*PW +: PW]
//  voice_bank       in   NVOICES*BANKW        per-voice bank select
//  RADDR            out  ADDRWIDTH            RAM read address
//  rbank            out  BANKW                RAM bank select
//  RCLK             out  1                    RAM read strobe
//  RDATA            in   DATAWIDTH            RAM data; valid the cycle after the RCLK strobe
//  dout             out  NVOICES*DATAWIDTH    per-voice output samples
//  dout_valid       out  1                    one-cycle pulse when dout updates
//  SUB_OUT          out  NVOICES              per-voice sub-oscillator square, fs/2 of the voice
//  busy             out  1                    FSM is not in IDLE
//  overrun          out  1                    sticky; sample_tick arrived while busy
//  EXT_READ_ENABLE  in   1                    level; selects external read mode
//  EXT_READ         in   1                    each rising edge requests one external read
//  ext_bank         in   BANKW                bank used by external reads
//  ext_data         out  DATAWIDTH            last externally read word
//  ext_ack          out  1                    one-cycle pulse when ext_data updates
// BEHAVIOUR
//  Reset values:
//   - phases = 0; every dout lane = 0x8000; SUB_OUT = 0.
//   - RADDR, rbank, RCLK, dout_valid, busy, overrun, ext_data, ext_ack, ext_addr = 0.
//  FSM states: IDLE, RD0, RD1, MAC, DONE, EXT_RD, EXT_CAP.
//  Frame start: IDLE & sample_tick & !EXT_READ_ENABLE -> RD0, with v = 0.
//  Per voice v; idx = phase_v[PW-1 -: AW], frac = phase_v[PW-AW-1 -: FRACW]:
//   - RD0: RADDR = idx, rbank = voice_bank[v], RCLK = 1.
//   - RD1: RADDR = idx+1 (wraps 2^AW-1 -> 0, same bank), RCLK = 1; capture s0 = RDATA.
//   - MAC: capture s1 = RDATA.
//       y = s0 + ((s1-s0)*frac) >>> FRACW, computed as a signed (DATAWIDTH+1)-bit difference, floor shift.
//       y is written to the shadow buffer lane v.
//       phase_v <= phase_v + fs_v mod 2^PW; carry-out toggles SUB_OUT[v].
//       v < NVOICES-1 -> RD0 with v+1; otherwise -> DONE.
//   - DONE: shadow buffer copied to dout, dout_valid = 1 for this cycle, -> IDLE.
//  Timing: 3 cycles per voice; dout_valid asserts 3*NVOICES+1 cycles after the sample_tick cycle.
//  dout for frame k uses the phase held before the frame-k update, so the first frame reads phase 0.
//  RCLK is high only in RD0, RD1 and EXT_RD; RADDR and rbank hold their last value otherwise.
//  sample_tick while busy: ignored; overrun <= 1, cleared only by reset.
//  Any voice_fs value is legal, including 0 (output constant, SUB_OUT static).
//  External mode:
//   - Rising edge of EXT_READ_ENABLE clears ext_addr and forces every dout lane to 0x8000 (no dout_valid pulse).
//   - While EXT_READ_ENABLE = 1: dout is held at 0x8000, phases frozen, sample_tick ignored (no overrun).
//   - Enable raised mid-frame: the current frame completes normally, then the mode applies.
//   - IDLE & EXT_READ_ENABLE & EXT_READ rising edge (registered edge detect) -> EXT_RD.
//   - EXT_RD: RADDR = ext_addr, rbank = ext_bank, RCLK = 1.
//   - EXT_CAP: ext_data <= RDATA, ext_ack = 1, ext_addr++ (wraps at 2^AW), -> IDLE.
//   - EXT_READ held high or falling: no action. Edge during EXT_RD/EXT_CAP is dropped.
//   - Dropping EXT_READ_ENABLE resumes synthesis from the frozen phases; dout stays 0x8000 until the next DONE.
//  Reset mid-operation: FSM -> IDLE; all state returns to its reset value.
// TESTING (RAM model RDATA <= {RADDR,8'h00} on RCLK; NVOICES = 2)
//  1 Reset -> dout = {0x8000,0x8000}, RCLK = 0, busy = 0, SUB_OUT = 0.
//  2 fs0 = 0x018000, two ticks -> frame 1 lane0 = 0x0000; frame 2 lane0 = 0x0180 (idx 1, frac 0x80);
//    dout_valid exactly 7 cycles after each tick.
//  3 fs0 = 0xFF8000 -> frame 2 reads addr 0xFF then 0x00; lane0 = 0x7F80; SUB_OUT[0] = 1 after frame 2.
//  4 Second tick 2 cycles after the first -> ignored, overrun = 1, only one dout_valid pulse.
//  5 EXT_READ_ENABLE = 1, three EXT_READ pulses -> RADDR = 0,1,2; ext_data = 0x0000, 0x0100, 0x0200;
//    ext_ack x3; dout = 0x8000 throughout.
//  6 rst_n low during RD1 -> outputs return to reset values immediately; next tick restarts at voice 0, phase 0.

Source files
------------

// File: rtl/wavetable_poly_if.sv
// wavetable_poly_if: shared synchronous wavetable RAM read port
interface wavetable_poly_if #(
    parameter int DATAWIDTH = 16,
    parameter int ADDRWIDTH = 8,
    parameter int BANKW     = 2
);
    logic [ADDRWIDTH-1:0] RADDR;
    logic [BANKW-1:0]     rbank;
    logic                 RCLK;
    logic [DATAWIDTH-1:0] RDATA;
    modport master (output RADDR, rbank, RCLK, input RDATA);
    modport slave  (input RADDR, rbank, RCLK, output RDATA);
endinterface

// File: rtl/wavetable_poly.sv
// wavetable_poly: time-multiplexed N-voice linearly interpolating wavetable oscillator
module wavetable_poly #(
    parameter int DATAWIDTH  = 16,
    parameter int ADDRWIDTH  = 8,
    parameter int PHASEWIDTH = 24,
    parameter int FRACW      = 8,
    parameter int BANKW      = 2,
    parameter int NVOICES    = 4
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            sample_tick,
    input  logic [NVOICES*PHASEWIDTH-1:0]   voice_fs,
    input  logic [NVOICES*BANKW-1:0]        voice_bank,
    wavetable_poly_if.master                ram,
    output logic [NVOICES*DATAWIDTH-1:0]    dout,
    output logic                            dout_valid,
    output logic [NVOICES-1:0]              SUB_OUT,
    output logic                            busy,
    output logic                            overrun,
    input  logic                            EXT_READ_ENABLE,
    input  logic                            EXT_READ,
    input  logic [BANKW-1:0]                ext_bank,
    output logic [DATAWIDTH-1:0]            ext_data,
    output logic                            ext_ack
);
    localparam int DW    = DATAWIDTH;
    localparam int AW    = ADDRWIDTH;
    localparam int PW    = PHASEWIDTH;
    localparam int VW    = NVOICES > 1 ? $clog2(NVOICES) : 1;
    localparam int PRODW = DW + FRACW + 2;
    localparam logic [NVOICES*DW-1:0] MID = {NVOICES{1'b1, {(DW-1){1'b0}}}};

    typedef enum logic [2:0] {IDLE, RD0, RD1, MAC, DONE, EXT_RD, EXT_CAP} state_t;

    state_t                 state_q, state_d;
    logic [VW-1:0]          v_q, v_d;
    logic [NVOICES*PW-1:0]  phase_q, phase_d;
    logic [NVOICES*DW-1:0]  shadow_q, shadow_d, dout_q, dout_d;
    logic [NVOICES-1:0]     sub_q, sub_d;
    logic [DW-1:0]          s0_q, s0_d, ext_data_q, ext_data_d;
    logic [AW-1:0]          raddr_q, raddr_d, ext_addr_q, ext_addr_d, nidx;
    logic [BANKW-1:0]       rbank_q, rbank_d;
    logic                   rclk_q, rclk_d, dv_q, dv_d, busy_q, busy_d, ovr_q, ovr_d;
    logic                   ext_ack_q, ext_ack_d, ext_en_q, ext_rd_q, ext_rise, carry;
    logic [PW-1:0]          cur_ph, sum;
    logic [FRACW-1:0]       frac;
    logic signed [DW:0]     diff;
    logic signed [PRODW-1:0] prod;
    logic [DW-1:0]          y;

    // Next-state logic: frame sequencing, interpolation, phase advance and registered outputs
    always_comb begin
        cur_ph       = phase_q[int'(v_q)*PW +: PW];
        frac         = cur_ph[PW-AW-1 -: FRACW];
        diff         = $signed({1'b0, ram.RDATA}) - $signed({1'b0, s0_q});
        prod         = PRODW'(diff) * PRODW'($signed({1'b0, frac}));
        y            = s0_q + DW'(prod >>> FRACW);
        {carry, sum} = {1'b0, cur_ph} + {1'b0, voice_fs[int'(v_q)*PW +: PW]};
        ext_rise     = EXT_READ & ~ext_rd_q;
        state_d      = state_q;
        v_d          = v_q;
        phase_d      = phase_q;
        sub_d        = sub_q;
        s0_d         = s0_q;
        shadow_d     = shadow_q;
        ext_data_d   = ext_data_q;
        ext_addr_d   = ext_addr_q;
        case (state_q)
            IDLE: begin
                if (sample_tick && !EXT_READ_ENABLE) begin
                    state_d = RD0;
                    v_d     = '0;
                end else if (EXT_READ_ENABLE && ext_rise) begin
                    state_d = EXT_RD;
                end
            end
            RD0: state_d = RD1;
            RD1: begin
                s0_d    = ram.RDATA;
                state_d = MAC;
            end
            MAC: begin
                shadow_d[int'(v_q)*DW +: DW] = y;
                phase_d[int'(v_q)*PW +: PW]  = sum;
                sub_d[v_q]                   = sub_q[v_q] ^ carry;
                if (v_q == VW'(NVOICES-1)) begin
                    state_d = DONE;
                end else begin
                    state_d = RD0;
                    v_d     = v_q + VW'(1);
                end
            end
            DONE: state_d = IDLE;
            EXT_RD: state_d = EXT_CAP;
            EXT_CAP: begin
                ext_data_d = ram.RDATA;
                ext_addr_d = ext_addr_q + AW'(1);
                state_d    = IDLE;
            end
            default: state_d = IDLE;
        endcase
        if (EXT_READ_ENABLE && !ext_en_q) ext_addr_d = '0;
        nidx      = phase_q[int'(v_d)*PW + PW - AW +: AW];
        rclk_d    = (state_d == RD0) || (state_d == RD1) || (state_d == EXT_RD);
        raddr_d   = state_d == RD0 ? nidx : state_d == RD1 ? nidx + AW'(1) :
                    state_d == EXT_RD ? ext_addr_q : raddr_q;
        rbank_d   = state_d == RD0 ? voice_bank[int'(v_d)*BANKW +: BANKW] :
                    state_d == EXT_RD ? ext_bank : rbank_q;
        busy_d    = state_d != IDLE;
        dv_d      = state_d == DONE;
        ext_ack_d = state_q == EXT_CAP;
        ovr_d     = ovr_q | (sample_tick & ~EXT_READ_ENABLE & (state_q != IDLE));
        dout_d    = state_d == DONE ? shadow_d :
                    (EXT_READ_ENABLE && (state_q == IDLE || state_q == EXT_RD || state_q == EXT_CAP)) ? MID :
                    dout_q;
    end

    // State and output registers; reset returns every lane to midscale
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            v_q        <= '0;
            phase_q    <= '0;
            shadow_q   <= MID;
            dout_q     <= MID;
            sub_q      <= '0;
            s0_q       <= '0;
            ext_data_q <= '0;
            ext_addr_q <= '0;
            raddr_q    <= '0;
            rbank_q    <= '0;
            rclk_q     <= 1'b0;
            dv_q       <= 1'b0;
            busy_q     <= 1'b0;
            ovr_q      <= 1'b0;
            ext_ack_q  <= 1'b0;
            ext_en_q   <= 1'b0;
            ext_rd_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            v_q        <= v_d;
            phase_q    <= phase_d;
            shadow_q   <= shadow_d;
            dout_q     <= dout_d;
            sub_q      <= sub_d;
            s0_q       <= s0_d;
            ext_data_q <= ext_data_d;
            ext_addr_q <= ext_addr_d;
            raddr_q    <= raddr_d;
            rbank_q    <= rbank_d;
            rclk_q     <= rclk_d;
            dv_q       <= dv_d;
            busy_q     <= busy_d;
            ovr_q      <= ovr_d;
            ext_ack_q  <= ext_ack_d;
            ext_en_q   <= EXT_READ_ENABLE;
            ext_rd_q   <= EXT_READ;
        end
    end

    assign ram.RADDR  = raddr_q;
    assign ram.rbank  = rbank_q;
    assign ram.RCLK   = rclk_q;
    assign dout       = dout_q;
    assign dout_valid = dv_q;
    assign SUB_OUT    = sub_q;
    assign busy       = busy_q;
    assign overrun    = ovr_q;
    assign ext_data   = ext_data_q;
    assign ext_ack    = ext_ack_q;
endmodule

// File: tb/tb_wavetable_poly.sv
// tb_wavetable_poly: directed and randomized checks of wavetable_poly against an arithmetic reference model
module tb_wavetable_poly;
    logic        clk = 1'b0, rst_n = 1'b0, sample_tick = 1'b0;
    logic        EXT_READ_ENABLE = 1'b0, EXT_READ = 1'b0;
    logic [47:0] voice_fs = '0;
    logic [3:0]  voice_bank = '0;
    logic [1:0]  ext_bank = '0;
    logic [31:0] dout;
    logic        dout_valid, busy, overrun, ext_ack;
    logic [1:0]  SUB_OUT;
    logic [15:0] ext_data;

    int          checks = 0, failures = 0;
    int          m_phase [2];
    logic [1:0]  m_sub;
    logic [31:0] exp_dout;
    logic [7:0]  seen [$];

    wavetable_poly_if #(.DATAWIDTH(16), .ADDRWIDTH(8), .BANKW(2)) ram ();

    wavetable_poly #(.NVOICES(2)) dut (
        .clk(clk), .rst_n(rst_n), .sample_tick(sample_tick),
        .voice_fs(voice_fs), .voice_bank(voice_bank), .ram(ram),
        .dout(dout), .dout_valid(dout_valid), .SUB_OUT(SUB_OUT),
        .busy(busy), .overrun(overrun),
        .EXT_READ_ENABLE(EXT_READ_ENABLE), .EXT_READ(EXT_READ),
        .ext_bank(ext_bank), .ext_data(ext_data), .ext_ack(ext_ack)
    );

    always #5 clk = ~clk;

    // RAM model: word = {address, bank in the low bits} so a wrong bank select is visible
    always @(posedge clk) if (ram.RCLK) ram.RDATA <= {ram.RADDR, 6'b0, ram.rbank};

    function automatic int samp(int a, int b);
        return (a % 256) * 256 + b;
    endfunction

    task automatic check(string tag, logic [63:0] obs, logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc(int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        cyc(2);
        rst_n = 1'b1;
        cyc(1);
        m_phase[0] = 0; m_phase[1] = 0; m_sub = '0;
    endtask

    // One frame of the reference: interpolate from the current phase, then advance it
    task automatic model_frame();
        for (int v = 0; v < 2; v++) begin
            int ph, idx, frac, s0, s1, yy, nx, bk;
            ph   = m_phase[v];
            idx  = ph >> 16;
            frac = (ph >> 8) & 255;
            bk   = int'(voice_bank[v*2 +: 2]);
            s0   = samp(idx, bk);
            s1   = samp(idx + 1, bk);
            yy   = s0 + (((s1 - s0) * frac) >>> 8);
            exp_dout[v*16 +: 16] = 16'(yy);
            nx = ph + int'(voice_fs[v*24 +: 24]);
            if (nx >= 32'h0100_0000) m_sub[v] = ~m_sub[v];
            m_phase[v] = nx & 32'h00FF_FFFF;
        end
    endtask

    task automatic run_frame(output int lat);
        lat = -1;
        seen.delete();
        sample_tick = 1'b1;
        for (int n = 1; n <= 20 && lat < 0; n++) begin
            @(posedge clk); #1;
            sample_tick = 1'b0;
            if (ram.RCLK) seen.push_back(ram.RADDR);
            if (dout_valid) lat = n;
        end
    endtask

    task automatic frame_check(string tag);
        int lat;
        run_frame(lat);
        model_frame();
        check({tag, "_lat"}, 64'(lat), 64'd7);
        check({tag, "_dout"}, {32'd0, dout}, {32'd0, exp_dout});
        check({tag, "_sub"}, {62'd0, SUB_OUT}, {62'd0, m_sub});
        cyc(1);
    endtask

    initial begin
        int pulses, acks, flag;
        logic [15:0] xexp;
        m_phase[0] = 0; m_phase[1] = 0; m_sub = '0;
        // 1: reset state
        cyc(3);
        check("rst_dout", {32'd0, dout}, 64'h8000_8000);
        check("rst_rclk", {63'd0, ram.RCLK}, 64'd0);
        check("rst_busy", {63'd0, busy}, 64'd0);
        check("rst_sub", {62'd0, SUB_OUT}, 64'd0);
        check("rst_ovr", {63'd0, overrun}, 64'd0);
        check("rst_dv", {63'd0, dout_valid}, 64'd0);
        rst_n = 1'b1;
        cyc(1);
        // 2: fractional step, two frames
        voice_fs = {24'h000000, 24'h018000};
        frame_check("t2a");
        check("t2a_lane0", {48'd0, dout[15:0]}, 64'h0000);
        frame_check("t2b");
        check("t2b_lane0", {48'd0, dout[15:0]}, 64'h0180);
        // 3: table wrap and sub-oscillator toggle
        do_reset();
        voice_fs = {24'h000100, 24'hFF8000};
        frame_check("t3a");
        frame_check("t3b");
        check("t3_nreads", 64'(seen.size()), 64'd4);
        check("t3_addr0", {56'd0, seen[0]}, 64'hFF);
        check("t3_addr1", {56'd0, seen[1]}, 64'h00);
        check("t3_lane0", {48'd0, dout[15:0]}, 64'h7F80);
        check("t3_sub0", {63'd0, SUB_OUT[0]}, 64'd1);
        // 4: tick while busy
        sample_tick = 1'b1;
        pulses = 0;
        for (int n = 1; n <= 20; n++) begin
            @(posedge clk); #1;
            sample_tick = (n == 2);
            pulses += int'(dout_valid);
        end
        model_frame();
        check("t4_pulses", 64'(pulses), 64'd1);
        check("t4_ovr", {63'd0, overrun}, 64'd1);
        check("t4_dout", {32'd0, dout}, {32'd0, exp_dout});
        // randomized frames with varying increments and banks
        do_reset();
        for (int i = 0; i < 12; i++) begin
            voice_fs   = (i == 0) ? 48'd0 : {24'($urandom), 24'($urandom)};
            voice_bank = 4'($urandom);
            frame_check("rnd");
            cyc($urandom_range(0, 3));
        end
        // 5: external read mode
        check("t5_ovr0", {63'd0, overrun}, 64'd0);
        EXT_READ_ENABLE = 1'b1;
        cyc(2);
        check("t5_dout_mid", {32'd0, dout}, 64'h8000_8000);
        sample_tick = 1'b1;
        flag = 0;
        for (int n = 0; n < 10; n++) begin
            @(posedge clk); #1;
            sample_tick = 1'b0;
            flag |= int'(busy | dout_valid);
        end
        check("t5_tick_ignored", 64'(flag), 64'd0);
        check("t5_no_ovr", {63'd0, overrun}, 64'd0);
        for (int k = 0; k < 4; k++) begin
            ext_bank = (k == 3) ? 2'd3 : 2'd0;
            xexp = (k == 3) ? 16'h0303 : 16'(k << 8);
            seen.delete();
            acks = 0;
            EXT_READ = 1'b1;
            for (int n = 1; n <= 8; n++) begin
                @(posedge clk); #1;
                EXT_READ = (n < 3);
                if (ram.RCLK) seen.push_back(ram.RADDR);
                acks += int'(ext_ack);
            end
            check("t5_acks", 64'(acks), 64'd1);
            check("t5_nreads", 64'(seen.size()), 64'd1);
            check("t5_addr", {56'd0, seen[0]}, 64'(k));
            check("t5_data", {48'd0, ext_data}, {48'd0, xexp});
            check("t5_dout_hold", {32'd0, dout}, 64'h8000_8000);
        end
        EXT_READ_ENABLE = 1'b0;
        cyc(1);
        check("t5_dout_after", {32'd0, dout}, 64'h8000_8000);
        frame_check("t5_resume");
        // 6: reset during RD1
        voice_fs = {24'h123456, 24'h0ABCDE};
        sample_tick = 1'b1;
        cyc(1);
        sample_tick = 1'b0;
        cyc(1);
        check("t6_rd1_rclk", {63'd0, ram.RCLK}, 64'd1);
        check("t6_rd1_addr", {56'd0, ram.RADDR}, 64'(((m_phase[0] >> 16) + 1) % 256));
        rst_n = 1'b0;
        #1;
        check("t6_dout", {32'd0, dout}, 64'h8000_8000);
        check("t6_busy", {63'd0, busy}, 64'd0);
        check("t6_rclk", {63'd0, ram.RCLK}, 64'd0);
        check("t6_sub", {62'd0, SUB_OUT}, 64'd0);
        cyc(2);
        rst_n = 1'b1;
        cyc(1);
        m_phase[0] = 0; m_phase[1] = 0; m_sub = '0;
        frame_check("t6_restart");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
